// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding imem read, one-entry skid buffer, redirect flush.
// Optional misaligned-redirect detection is enabled by defining FETCH_ALIGN_CHECK_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        id_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic [5:0]  op,
  output logic        misalign_err
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] drain_addr_reg, drain_addr_next;
  logic        if_valid_reg, if_valid_next;
  logic [31:0] if_instr_reg, if_instr_next;
  logic [31:0] if_pc_reg, if_pc_next;
  logic [31:0] buf_instr_reg, buf_instr_next;
  logic [31:0] buf_pc_reg, buf_pc_next;

  logic        ack_q;
  logic        xfer;
  logic        slot_free;
  logic [31:0] target_pc;

  // The bus is only driven outside reset and outside HOLD; an ack without a request is ignored.
  assign imem_req  = !reset && (state_reg != HOLD);
  assign imem_addr = (state_reg == DRAIN) ? drain_addr_reg : pc_reg;
  assign ack_q     = imem_ack && imem_req;
  assign xfer      = if_valid_reg && id_ready;
  assign slot_free = !if_valid_reg || xfer;
  assign target_pc = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    drain_addr_next = drain_addr_reg;
    if_valid_next   = if_valid_reg;
    if_instr_next   = if_instr_reg;
    if_pc_next      = if_pc_reg;
    buf_instr_next  = buf_instr_reg;
    buf_pc_next     = buf_pc_reg;
    if (redirect) begin
      // Redirect wins over everything: flush the output slot and any buffered word.
      pc_next       = target_pc;
      if_valid_next = 1'b0;
      case (state_reg)
        FETCH: begin
          if (!ack_q) begin
            state_next      = DRAIN;
            drain_addr_next = pc_reg;
          end
        end
        HOLD:    state_next = FETCH;
        default: if (ack_q) state_next = FETCH;
      endcase
    end else begin
      case (state_reg)
        FETCH: begin
          if (ack_q) begin
            pc_next = pc_reg + 32'd4;
            if (slot_free) begin
              if_instr_next = imem_rdata;
              if_pc_next    = pc_reg;
              if_valid_next = 1'b1;
            end else begin
              buf_instr_next = imem_rdata;
              buf_pc_next    = pc_reg;
              state_next     = HOLD;
            end
          end else if (xfer) begin
            if_valid_next = 1'b0;
          end
        end
        HOLD: begin
          if (xfer) begin
            if_instr_next = buf_instr_reg;
            if_pc_next    = buf_pc_reg;
            state_next    = FETCH;
          end
        end
        default: begin
          // The word returned for the abandoned address is dropped.
          if (ack_q) state_next = FETCH;
          if (xfer) if_valid_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC & 32'hFFFF_FFFC;
      drain_addr_reg <= 32'h0;
      if_valid_reg   <= 1'b0;
      if_instr_reg   <= 32'h0;
      if_pc_reg      <= 32'h0;
      buf_instr_reg  <= 32'h0;
      buf_pc_reg     <= 32'h0;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      drain_addr_reg <= drain_addr_next;
      if_valid_reg   <= if_valid_next;
      if_instr_reg   <= if_instr_next;
      if_pc_reg      <= if_pc_next;
      buf_instr_reg  <= buf_instr_next;
      buf_pc_reg     <= buf_pc_next;
    end
  end

  assign if_valid = if_valid_reg;
  assign if_instr = if_instr_reg;
  assign if_pc    = if_pc_reg;
  assign if_pc4   = if_pc_reg + 32'd4;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_op
      assign op[gi] = if_instr_reg[26 + gi];
    end
  endgenerate

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_reg <= 1'b0;
    end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
      misalign_reg <= 1'b1;
    end
  end

  assign misalign_err = misalign_reg;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch: stream, stall/hold, redirects, misalign, reset mid-access.
`timescale 1ns/1ps
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic [5:0]  op;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;

  int   lat = 1;
  int   wait_cnt = 0;
  logic stray = 1'b0;

`ifdef FETCH_ALIGN_CHECK_EN
  logic exp_mis = 1'b1;
`else
  logic exp_mis = 1'b0;
`endif

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_pc4(if_pc4),
    .op(op), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Memory: word N holds N, except address 0x1C holds an lw; ack after lat cycles of request.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #3;
      if (stray) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        wait_cnt   = 0;
      end else if (imem_req && (wait_cnt >= lat - 1)) begin
        imem_ack   = 1'b1;
        imem_rdata = (imem_addr == 32'h0000_001C) ? 32'h8C01_0004 : (imem_addr >> 2);
        wait_cnt   = 0;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        wait_cnt   = imem_req ? wait_cnt + 1 : 0;
      end
    end
  end

  always @(posedge clk) begin
    if (!reset && if_valid && id_ready)
      $display("xfer pc=%h instr=%h op=%h", if_pc, if_instr, op);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
    tick();
    tick();
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_valid); end
    checks++; if (if_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got %h want 0", if_instr); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", if_pc); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL reset_mis got %b want 0", misalign_err); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    reset = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b want 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL first_addr got %h want 0", imem_addr); end
    tick();
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %b want 1", if_valid); end
    checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL first_pc got %h want 0", if_pc); end
    checks++; if (if_pc4 !== 32'h4) begin errors++; $display("FAIL first_pc4 got %h want 4", if_pc4); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [5:0]  exp_op;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp_pc    = 32'(4 * i);
      exp_instr = (i == 7) ? 32'h8C01_0004 : 32'(i);
      exp_op    = (i == 7) ? 6'h23 : 6'h00;
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b want 1", i, if_valid); end
      checks++; if (if_pc !== exp_pc) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, if_pc, exp_pc); end
      checks++; if (if_instr !== exp_instr) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", i, if_instr, exp_instr); end
      checks++; if (if_pc4 !== exp_pc + 32'd4) begin errors++; $display("FAIL stream_pc4[%0d] got %h want %h", i, if_pc4, exp_pc + 32'd4); end
      checks++; if (op !== exp_op) begin errors++; $display("FAIL stream_op[%0d] got %h want %h", i, op, exp_op); end
    end
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b want 1", i, if_valid); end
      checks++; if (if_pc !== 32'h1C) begin errors++; $display("FAIL stall_pc[%0d] got %h want 0000001c", i, if_pc); end
      checks++; if (if_instr !== 32'h8C01_0004) begin errors++; $display("FAIL stall_instr[%0d] got %h want 8c010004", i, if_instr); end
      checks++; if (op !== 6'h23) begin errors++; $display("FAIL stall_op[%0d] got %h want 23", i, op); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req[%0d] got %b want 0", i, imem_req); end
    end
    id_ready = 1'b1;
    tick();
    checks++; if (if_pc !== 32'h20) begin errors++; $display("FAIL hold_pc got %h want 00000020", if_pc); end
    checks++; if (if_instr !== 32'h8) begin errors++; $display("FAIL hold_instr got %h want 00000008", if_instr); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h24) begin errors++; $display("FAIL resume_req got %b/%h want 1/00000024", imem_req, imem_addr); end
    tick();
    checks++; if (if_pc !== 32'h24 || if_valid !== 1'b1) begin errors++; $display("FAIL resume_pc got %h/%b want 00000024/1", if_pc, if_valid); end
  endtask

  task automatic test_redirect_latency();
    bit found = 0;
    lat = 3;
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL drain_valid[%0d] got %b want 0", i, if_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h28) begin errors++; $display("FAIL drain_addr[%0d] got %b/%h want 1/00000028", i, imem_req, imem_addr); end
      tick();
    end
    checks++; if (imem_addr !== 32'h100 || if_valid !== 1'b0) begin errors++; $display("FAIL refetch_addr got %h/%b want 00000100/0", imem_addr, if_valid); end
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (if_valid) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL redir_timeout got no valid want valid"); end
    checks++; if (if_pc !== 32'h100 || if_instr !== 32'h40) begin errors++; $display("FAIL redir_first got %h/%h want 00000100/00000040", if_pc, if_instr); end
  endtask

  task automatic test_redirect_ack();
    lat = 1;
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rack_flush got %b want 0", if_valid); end
    checks++; if (imem_addr !== 32'h200 || imem_req !== 1'b1) begin errors++; $display("FAIL rack_addr got %h/%b want 00000200/1", imem_addr, imem_req); end
    tick();
    checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== 32'h80) begin errors++; $display("FAIL rack_first got %b/%h/%h want 1/00000200/00000080", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_misalign();
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    checks++; if (misalign_err !== exp_mis) begin errors++; $display("FAIL mis_flag got %b want %b", misalign_err, exp_mis); end
    checks++; if (imem_addr !== 32'h100 || if_valid !== 1'b0) begin errors++; $display("FAIL mis_addr got %h/%b want 00000100/0", imem_addr, if_valid); end
    tick();
    checks++; if (if_pc !== 32'h100 || if_instr !== 32'h40) begin errors++; $display("FAIL mis_first got %h/%h want 00000100/00000040", if_pc, if_instr); end
    tick();
    checks++; if (misalign_err !== exp_mis) begin errors++; $display("FAIL mis_sticky got %b want %b", misalign_err, exp_mis); end
    checks++; if (if_pc !== 32'h104) begin errors++; $display("FAIL mis_next got %h want 00000104", if_pc); end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    lat = 4;
    tick();
    reset = 1'b1; stray = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rmid_req got %b want 0", imem_req); end
    tick();
    checks++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0) begin errors++; $display("FAIL rmid_regs got %b/%h/%h want 0/0/0", if_valid, if_pc, if_instr); end
    checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rmid_mis got %b want 0", misalign_err); end
    tick();
    reset = 1'b0; stray = 1'b0; lat = 2;
    #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rmid_fetch got %b/%h want 1/00000000", imem_req, imem_addr); end
    for (int i = 0; i < 6 && !found; i++) begin
      tick();
      if (if_valid) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL rmid_timeout got no valid want valid"); end
    checks++; if (if_pc !== 32'h0 || if_instr !== 32'h0) begin errors++; $display("FAIL rmid_first got %h/%h want 0/0", if_pc, if_instr); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_latency();
    test_redirect_ack();
    test_misalign();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
